// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (imem)
// and load/store (dmem). Each requester gets a single pending slot. Grants
// alternate when both slots are full, the downstream request is issued for
// one registered cycle, and the response is routed back to its owner. A
// watchdog gives up on a silent memory and flags the event.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int FETCH_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 imem_rd_en_i,
  input  logic [DATA_WIDTH-1:0]                imem_addr_i,
  output logic                                 imem_busy_o,
  output logic                                 imem_rdy_o,
  output logic [31:0]                          imem_rd_data_o,
  input  logic                                 dmem_rd_en_i,
  input  logic                                 dmem_wr_en_i,
  input  logic [DATA_WIDTH-1:0]                dmem_addr_i,
  input  logic [$clog2(FETCH_WIDTH/8)-1:0]     dmem_wr_size_i,
  input  logic [FETCH_WIDTH-1:0]               dmem_wr_data_i,
  output logic                                 dmem_busy_o,
  output logic                                 dmem_rdy_o,
  output logic [FETCH_WIDTH-1:0]               dmem_rd_data_o,
  output logic                                 mem_rd_en_o,
  output logic                                 mem_wr_en_o,
  output logic [DATA_WIDTH-1:0]                mem_addr_o,
  output logic [$clog2(FETCH_WIDTH/8)-1:0]     mem_wr_size_o,
  output logic [FETCH_WIDTH-1:0]               mem_wr_data_o,
  input  logic                                 mem_busy_i,
  input  logic                                 mem_rdy_i,
  input  logic [FETCH_WIDTH-1:0]               mem_rd_data_i,
  output logic                                 err_timeout_o
);

  localparam int SIZE_W    = $clog2(FETCH_WIDTH/8);
  localparam int NUM_LANES = FETCH_WIDTH/32;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  state_e                  state_q, state_d;
  port_e                   owner_q, owner_d;
  port_e                   lastGrant_q, lastGrant_d;
  logic                    iPending_q, iPending_d;
  logic [DATA_WIDTH-1:0]   iAddr_q, iAddr_d;
  logic                    dPending_q, dPending_d;
  logic                    dWrite_q, dWrite_d;
  logic [DATA_WIDTH-1:0]   dAddr_q, dAddr_d;
  logic [SIZE_W-1:0]       dSize_q, dSize_d;
  logic [FETCH_WIDTH-1:0]  dData_q, dData_d;
  logic [CNT_W-1:0]        wdCount_q, wdCount_d;
  logic                    errTimeout_q, errTimeout_d;
  logic                    memRdEn_q, memRdEn_d;
  logic                    memWrEn_q, memWrEn_d;
  logic [DATA_WIDTH-1:0]   memAddr_q, memAddr_d;
  logic [SIZE_W-1:0]       memSize_q, memSize_d;
  logic [FETCH_WIDTH-1:0]  memData_q, memData_d;

  logic                    timeoutHit;
  logic                    respond;
  logic                    iRdy;
  logic                    dRdy;
  logic [LANE_W-1:0]       laneSel;
  logic [31:0]             fetchWord;

  // The 32-bit fetch lane comes from the address bits just above the word offset.
  if (NUM_LANES > 1) begin : gLaneSel
    assign laneSel = iAddr_q[LANE_W+1:2];
  end else begin : gSingleLane
    assign laneSel = 1'b0;
  end

  // Pick the selected 32-bit lane out of the wide memory word.
  always_comb begin
    fetchWord = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (laneSel == LANE_W'(l)) fetchWord = mem_rd_data_i[l*32 +: 32];
    end
  end

  // Response detection: a real memory response, or the watchdog giving up.
  always_comb begin
    timeoutHit = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && !mem_rdy_i &&
                 (wdCount_q == CNT_W'(TIMEOUT_CYCLES));
    respond    = ((state_q == ISSUE) || (state_q == WAIT)) && (mem_rdy_i || timeoutHit);
  end

  // Next-state logic: request capture, arbitration, issue and response.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lastGrant_d  = lastGrant_q;
    iPending_d   = iPending_q;
    iAddr_d      = iAddr_q;
    dPending_d   = dPending_q;
    dWrite_d     = dWrite_q;
    dAddr_d      = dAddr_q;
    dSize_d      = dSize_q;
    dData_d      = dData_q;
    wdCount_d    = wdCount_q;
    errTimeout_d = errTimeout_q | timeoutHit;
    memRdEn_d    = 1'b0;
    memWrEn_d    = 1'b0;
    memAddr_d    = '0;
    memSize_d    = '0;
    memData_d    = '0;

    case (state_q)
      IDLE: begin
        if ((iPending_q || dPending_q) && !mem_busy_i) begin
          if (iPending_q && dPending_q) begin
            owner_d = (lastGrant_q == PORT_I) ? PORT_D : PORT_I;
          end else begin
            owner_d = dPending_q ? PORT_D : PORT_I;
          end
          if (owner_d == PORT_D) begin
            memRdEn_d = !dWrite_q;
            memWrEn_d = dWrite_q;
            memAddr_d = dAddr_q;
            memSize_d = dSize_q;
            memData_d = dData_q;
          end else begin
            memRdEn_d = 1'b1;
            memAddr_d = iAddr_q;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdCount_d = '0;
        state_d   = respond ? IDLE : WAIT;
      end
      WAIT: begin
        if (respond) begin
          state_d = IDLE;
        end else begin
          wdCount_d = wdCount_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (respond) begin
      lastGrant_d = owner_q;
      if (owner_q == PORT_I) iPending_d = 1'b0;
      else                   dPending_d = 1'b0;
    end

    if (imem_rd_en_i && !iPending_q) begin
      iPending_d = 1'b1;
      iAddr_d    = imem_addr_i;
    end

    if ((dmem_rd_en_i || dmem_wr_en_i) && !dPending_q) begin
      dPending_d = 1'b1;
      dWrite_d   = dmem_wr_en_i;
      dAddr_d    = dmem_addr_i;
      dSize_d    = dmem_wr_size_i;
      dData_d    = dmem_wr_data_i;
    end
  end

  // State and slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      lastGrant_q  <= PORT_I;
      iPending_q   <= 1'b0;
      iAddr_q      <= '0;
      dPending_q   <= 1'b0;
      dWrite_q     <= 1'b0;
      dAddr_q      <= '0;
      dSize_q      <= '0;
      dData_q      <= '0;
      wdCount_q    <= '0;
      errTimeout_q <= 1'b0;
      memRdEn_q    <= 1'b0;
      memWrEn_q    <= 1'b0;
      memAddr_q    <= '0;
      memSize_q    <= '0;
      memData_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastGrant_q  <= lastGrant_d;
      iPending_q   <= iPending_d;
      iAddr_q      <= iAddr_d;
      dPending_q   <= dPending_d;
      dWrite_q     <= dWrite_d;
      dAddr_q      <= dAddr_d;
      dSize_q      <= dSize_d;
      dData_q      <= dData_d;
      wdCount_q    <= wdCount_d;
      errTimeout_q <= errTimeout_d;
      memRdEn_q    <= memRdEn_d;
      memWrEn_q    <= memWrEn_d;
      memAddr_q    <= memAddr_d;
      memSize_q    <= memSize_d;
      memData_q    <= memData_d;
    end
  end

  // Outputs are held quiet while reset is asserted so nothing leaks out mid-reset.
  always_comb begin
    iRdy           = !rst && respond && (owner_q == PORT_I);
    dRdy           = !rst && respond && (owner_q == PORT_D);
    imem_rdy_o     = iRdy;
    dmem_rdy_o     = dRdy;
    imem_rd_data_o = (iRdy && mem_rdy_i) ? fetchWord : '0;
    dmem_rd_data_o = (dRdy && mem_rdy_i) ? mem_rd_data_i : '0;
    imem_busy_o    = !rst && iPending_q;
    dmem_busy_o    = !rst && dPending_q;
    mem_rd_en_o    = !rst && memRdEn_q;
    mem_wr_en_o    = !rst && memWrEn_q;
    mem_addr_o     = rst ? '0 : memAddr_q;
    mem_wr_size_o  = rst ? '0 : memSize_q;
    mem_wr_data_o  = rst ? '0 : memData_q;
    err_timeout_o  = !rst && errTimeout_q;
  end

endmodule
